// File: rtl/btb_pkg.sv
// btb_pkg: shared entry type, tag width and direction-counter helpers for the BTB
package btb_pkg;
    localparam int unsigned TAG_MAX = 30;
    localparam int unsigned CTR_MAX = 8;
    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
        logic [CTR_MAX-1:0] ctr;
    } btb_entry_t;
    function automatic int unsigned tag_width(input int unsigned iw);
        return 30 - iw;
    endfunction
    function automatic logic [CTR_MAX-1:0] ctr_max(input int unsigned w);
        return CTR_MAX'((1 << w) - 1);
    endfunction
    function automatic logic [CTR_MAX-1:0] ctr_init(input int unsigned w);
        return CTR_MAX'(1 << (w - 1));
    endfunction
    function automatic logic [CTR_MAX-1:0] sat_inc(input logic [CTR_MAX-1:0] c, input int unsigned w);
        return (c == ctr_max(w)) ? c : c + 1'b1;
    endfunction
    function automatic logic [CTR_MAX-1:0] sat_dec(input logic [CTR_MAX-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction
endpackage

// File: rtl/btb_way.sv
// btb_way: one way of the BTB; two async read ports, one write port, valid clear-all
module btb_way
    import btb_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   we_i,
    input  logic [INDEX_WIDTH-1:0] widx_i,
    input  btb_entry_t             wdata_i,
    input  logic [INDEX_WIDTH-1:0] ra_idx_i,
    input  logic [INDEX_WIDTH-1:0] rb_idx_i,
    output btb_entry_t             ra_o,
    output btb_entry_t             rb_o
);
    localparam int unsigned SETS = 2 ** INDEX_WIDTH;
    logic [SETS-1:0] valid_q, valid_d;
    btb_entry_t      mem_q [SETS];
    btb_entry_t      mem_d [SETS];
    always_comb begin
        valid_d = valid_q;
        mem_d   = mem_q;
        if (clr_i) valid_d = '0;
        else if (we_i) begin
            valid_d[widx_i] = wdata_i.valid;
            mem_d[widx_i]   = wdata_i;
        end
        ra_o       = mem_q[ra_idx_i];
        ra_o.valid = mem_q[ra_idx_i].valid & valid_q[ra_idx_i];
        rb_o       = mem_q[rb_idx_i];
        rb_o.valid = mem_q[rb_idx_i].valid & valid_q[rb_idx_i];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) valid_q <= '0;
        else       valid_q <= valid_d;
    end
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative BTB with combinational lookup, saturating counters and round-robin refill
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned CTR_WIDTH   = 2,
    localparam int unsigned WW         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic [31:0]   lk_pc_i,
    output logic          lk_hit_o,
    output logic          lk_taken_o,
    output logic [31:0]   lk_target_o,
    output logic [WW-1:0] lk_way_o,
    input  logic          upd_valid_i,
    input  logic [31:0]   upd_pc_i,
    input  logic          upd_taken_i,
    input  logic [31:0]   upd_target_i
);
    localparam int unsigned SETS = 2 ** INDEX_WIDTH;
    localparam int unsigned TW   = tag_width(INDEX_WIDTH);
    logic [INDEX_WIDTH-1:0]     lk_idx, upd_idx;
    logic [TAG_MAX-1:0]         lk_tag, upd_tag;
    btb_entry_t                 lk_e [WAYS];
    btb_entry_t                 up_e [WAYS];
    btb_entry_t                 wdata;
    logic [WAYS-1:0]            we;
    logic                       hit, inv;
    logic [WW-1:0]              hit_way, inv_way, vic;
    logic [SETS-1:0][WW-1:0]    rr_q, rr_d;
    logic                       unused;
    assign unused  = ^{lk_pc_i[1:0], upd_pc_i[1:0]};
    assign lk_idx  = lk_pc_i[INDEX_WIDTH+1:2];
    assign upd_idx = upd_pc_i[INDEX_WIDTH+1:2];
    assign lk_tag  = TAG_MAX'(lk_pc_i[31:INDEX_WIDTH+2]);
    assign upd_tag = TAG_MAX'(upd_pc_i[31:INDEX_WIDTH+2]);
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_way #(.INDEX_WIDTH(INDEX_WIDTH)) u_way (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (flush_i),
            .we_i    (we[w]),
            .widx_i  (upd_idx),
            .wdata_i (wdata),
            .ra_idx_i(lk_idx),
            .rb_idx_i(upd_idx),
            .ra_o    (lk_e[w]),
            .rb_o    (up_e[w])
        );
    end
    always_comb begin
        lk_hit_o    = 1'b0;
        lk_taken_o  = 1'b0;
        lk_target_o = '0;
        lk_way_o    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lk_e[w].valid && lk_e[w].tag == lk_tag) begin
                lk_hit_o    = 1'b1;
                lk_taken_o  = lk_e[w].ctr[CTR_WIDTH-1];
                lk_target_o = lk_e[w].target;
                lk_way_o    = WW'(w);
            end
        end
    end
    // Descending scan so the lowest-index invalid way ends up as the refill candidate.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv     = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (up_e[w].valid && up_e[w].tag == upd_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!up_e[w].valid) begin
                inv     = 1'b1;
                inv_way = WW'(w);
            end
        end
        vic   = inv ? inv_way : rr_q[upd_idx];
        rr_d  = rr_q;
        we    = '0;
        wdata = up_e[hit_way];
        if (flush_i) rr_d = '0;
        else if (upd_valid_i && hit) begin
            we[hit_way]  = 1'b1;
            wdata.ctr    = upd_taken_i ? sat_inc(up_e[hit_way].ctr, CTR_WIDTH) : sat_dec(up_e[hit_way].ctr);
            wdata.target = upd_taken_i ? upd_target_i : up_e[hit_way].target;
        end else if (upd_valid_i && upd_taken_i) begin
            we[vic]      = 1'b1;
            wdata.valid  = 1'b1;
            wdata.tag    = upd_tag;
            wdata.target = upd_target_i;
            wdata.ctr    = ctr_init(CTR_WIDTH);
            if (!inv && WAYS > 1) rr_d[upd_idx] = rr_q[upd_idx] + 1'b1;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_q <= '0;
        else       rr_q <= rr_d;
    end
endmodule
